// File: rtl/fact_pkg.sv
// Shared types and helpers for the factorial sequencing controller.
// Output decode lives here so every state maps to its strobes in one place.
package fact_pkg;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    CHECK,
    MULT,
    DONE,
    ERR
  } fact_state_t;

  localparam int FACT_N_MAX = 12;

  typedef struct packed {
    logic load_cnt;
    logic en;
    logic sel_1;
    logic load_reg;
    logic sel_2;
    logic busy;
    logic done;
    logic err;
  } fact_out_t;

  // Moore decode: strobes are a pure function of the state being entered.
  function automatic fact_out_t fact_decode(input fact_state_t s);
    fact_out_t o;
    o = '0;
    case (s)
      LOAD: begin
        o.load_cnt = 1'b1;
        o.load_reg = 1'b1;
        o.busy     = 1'b1;
      end
      CHECK: o.busy = 1'b1;
      MULT: begin
        o.sel_1    = 1'b1;
        o.load_reg = 1'b1;
        o.en       = 1'b1;
        o.busy     = 1'b1;
      end
      DONE: begin
        o.sel_2 = 1'b1;
        o.done  = 1'b1;
      end
      ERR:     o.err = 1'b1;
      default: o = '0;
    endcase
    return o;
  endfunction

endpackage

// File: rtl/rise_det.sv
// Registered rising-edge detector; the delayed copy clears on reset, so a level
// held high through reset reads as a rise in the first cycle afterwards.
module rise_det (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic rise
);

  logic d_q;

  always_ff @(posedge clk) begin
    if (!rst) d_q <= 1'b0;
    else      d_q <= d;
  end

  assign rise = d & ~d_q;

endmodule

// File: rtl/fact_ctrl.sv
// Sequencing controller for the factorial datapath: range check, then alternating
// CHECK/MULT steps until the count reaches 1, with a saturating busy-cycle counter.
module fact_ctrl
  import fact_pkg::*;
#(
  parameter int CYC_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             go,
  input  logic             gt_in,
  input  logic             gt_fact,
  output logic             load_cnt,
  output logic             en,
  output logic             sel_1,
  output logic             load_reg,
  output logic             sel_2,
  output logic             busy,
  output logic             done,
  output logic             err,
  output logic [CYC_W-1:0] cyc
);

  fact_state_t state;
  fact_out_t   outs;
  logic        go_rise;

  rise_det u_go_rise (
    .clk  (clk),
    .rst  (rst),
    .d    (go),
    .rise (go_rise)
  );

  // Outputs are registered alongside the state, decoded from the state being entered.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      outs  <= '0;
      cyc   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (go_rise) begin
            cyc <= '0;
            if (gt_in) begin
              state <= ERR;
              outs  <= fact_decode(ERR);
            end else begin
              state <= LOAD;
              outs  <= fact_decode(LOAD);
            end
          end
        end
        LOAD: begin
          state <= CHECK;
          outs  <= fact_decode(CHECK);
        end
        CHECK: begin
          if (gt_fact) begin
            state <= MULT;
            outs  <= fact_decode(MULT);
          end else begin
            state <= DONE;
            outs  <= fact_decode(DONE);
          end
        end
        MULT: begin
          state <= CHECK;
          outs  <= fact_decode(CHECK);
        end
        default: begin
          state <= IDLE;
          outs  <= fact_decode(IDLE);
        end
      endcase
      // outs.busy mirrors the current state, so this counts busy cycles exactly.
      if (outs.busy && (cyc != {CYC_W{1'b1}})) cyc <= cyc + 1'b1;
    end
  end

  assign load_cnt = outs.load_cnt;
  assign en       = outs.en;
  assign sel_1    = outs.sel_1;
  assign load_reg = outs.load_reg;
  assign sel_2    = outs.sel_2;
  assign busy     = outs.busy;
  assign done     = outs.done;
  assign err      = outs.err;

endmodule

// File: tb/tb_fact_ctrl.sv
// Self-checking bench for fact_ctrl with a behavioural fact_dp model and a
// scoreboard of expected run results.
module tb_fact_ctrl;
  import fact_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        go = 1'b0;
  logic        gt_in, gt_fact;
  logic        load_cnt, en, sel_1, load_reg, sel_2, busy, done, err;
  logic [7:0]  cyc;
  logic [7:0]  n = 8'd0;
  logic [7:0]  cnt = 8'd0;
  logic [31:0] prod = 32'd0;
  logic [31:0] nf;

  int n_cmp = 0;
  int n_err = 0;

  typedef struct {
    logic        is_err;
    logic [31:0] nf;
    logic [7:0]  cyc;
    int          lat;
    int          mults;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  fact_ctrl #(.CYC_W(8)) dut (
    .clk      (clk),
    .rst      (rst),
    .go       (go),
    .gt_in    (gt_in),
    .gt_fact  (gt_fact),
    .load_cnt (load_cnt),
    .en       (en),
    .sel_1    (sel_1),
    .load_reg (load_reg),
    .sel_2    (sel_2),
    .busy     (busy),
    .done     (done),
    .err      (err),
    .cyc      (cyc)
  );

  // Datapath model: down-counter and product register driven by the controller strobes.
  assign gt_in   = n > 8'(FACT_N_MAX);
  assign gt_fact = cnt > 8'd1;
  assign nf      = sel_2 ? prod : 32'd0;

  always @(posedge clk) begin
    if (load_cnt)  cnt <= n;
    else if (en)   cnt <= cnt - 8'd1;
    if (load_reg)  prod <= sel_1 ? prod * 32'(cnt) : 32'd1;
  end

  function automatic logic [31:0] ref_fact(input int k);
    logic [31:0] r;
    r = 32'd1;
    for (int i = 2; i <= k; i++) r = r * 32'(i);
    return r;
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
    n_cmp++;
    assert (obs === expv) else begin
      n_err++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic push_exp(input int nv);
    exp_t e;
    if (nv > FACT_N_MAX) begin
      e.is_err = 1'b1; e.nf = 32'd0; e.cyc = 8'd0; e.lat = 1; e.mults = 0;
    end else if (nv < 2) begin
      e.is_err = 1'b0; e.nf = 32'd1; e.cyc = 8'd2; e.lat = 3; e.mults = 0;
    end else begin
      e.is_err = 1'b0; e.nf = ref_fact(nv); e.cyc = 8'(2 * nv);
      e.lat = 2 * nv + 1; e.mults = nv - 1;
    end
    sb.push_back(e);
  endtask

  // Called just after a negedge: raises go with operand nv and records the expectation.
  task automatic start_run(input int nv);
    n  = 8'(nv);
    go = 1'b1;
    push_exp(nv);
  endtask

  // Steps cycles t0+1.. until done/err, then pops the scoreboard and compares.
  task automatic wait_result(input bit hold_go, input bit toggle, input string tag);
    exp_t e;
    int   busy_n, mult_n, strobe_n, lat;
    bit   fin;
    busy_n = 0; mult_n = 0; strobe_n = 0; lat = -1; fin = 1'b0;
    e = sb[0];
    for (int k = 1; k <= 100 && !fin; k++) begin
      @(negedge clk);
      if (k == 1) begin
        check({tag, ".t1_load_cnt"}, load_cnt, !e.is_err);
        check({tag, ".t1_err"}, err, e.is_err);
        check({tag, ".t1_done"}, done, 1'b0);
      end
      if (!hold_go) go = 1'b0;
      if (toggle && k == 2) go = 1'b0;
      if (toggle && k == 3) go = 1'b1;
      if (busy) busy_n++;
      if (en) mult_n++;
      if (load_cnt | en | sel_1 | load_reg | sel_2) strobe_n++;
      if (done || err) begin
        fin = 1'b1;
        lat = k;
      end
    end
    check({tag, ".finished"}, fin, 1'b1);
    void'(sb.pop_front());
    check({tag, ".err"}, err, e.is_err);
    check({tag, ".done"}, done, !e.is_err);
    check({tag, ".nf"}, nf, e.nf);
    check({tag, ".cyc"}, cyc, e.cyc);
    check({tag, ".latency"}, lat, e.lat);
    check({tag, ".mults"}, mult_n, e.mults);
    check({tag, ".busy_cycles"}, busy_n, e.cyc);
    if (e.is_err) check({tag, ".strobes"}, strobe_n, 0);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".busy"}, busy, 1'b0);
    check({tag, ".done"}, done, 1'b0);
    check({tag, ".err"}, err, 1'b0);
    check({tag, ".cyc"}, cyc, 8'd0);
    check({tag, ".strobes"}, {load_cnt, en, sel_1, load_reg, sel_2}, 5'd0);
  endtask

  initial begin
    $display("[TB] start");
    repeat (3) @(negedge clk);
    check_quiet("reset");
    rst = 1'b1;
    @(negedge clk);
    check_quiet("idle");

    start_run(5);
    wait_result(1'b0, 1'b0, "n5");
    repeat (3) @(negedge clk);
    check("n5.sticky_done", done, 1'b1);
    check("n5.sticky_cyc", cyc, 8'd10);
    check("n5.sticky_nf", nf, 32'd120);

    start_run(0);
    wait_result(1'b0, 1'b0, "n0");
    start_run(1);
    wait_result(1'b0, 1'b0, "n1");

    start_run(13);
    wait_result(1'b0, 1'b0, "n13");
    repeat (2) @(negedge clk);
    check("n13.sticky_err", err, 1'b1);
    check("n13.sticky_busy", busy, 1'b0);
    start_run(12);
    wait_result(1'b0, 1'b0, "n12");

    start_run(5);
    wait_result(1'b1, 1'b1, "hold5");
    repeat (3) @(negedge clk);
    check("hold5.no_restart_done", done, 1'b1);
    check("hold5.no_restart_nf", nf, 32'd120);
    check("hold5.no_restart_cyc", cyc, 8'd10);
    go = 1'b0;
    @(negedge clk);
    start_run(4);
    wait_result(1'b0, 1'b0, "n4_from_done");

    n  = 8'd5;
    go = 1'b1;
    repeat (3) @(negedge clk);
    check("mid.in_mult", en, 1'b1);
    rst = 1'b0;
    @(negedge clk);
    check_quiet("mid_reset");
    rst = 1'b1;
    n   = 8'd3;
    push_exp(3);
    wait_result(1'b1, 1'b0, "rst_restart");
    go = 1'b0;
    @(negedge clk);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
